// File: rtl/vga_stitch_timing_pkg.sv
// Shared constants and types for the VGA 640x480@60 stitch-grid timing generator.
package vga_stitch_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int CELL_LOG2_DEF = 4;

  localparam int H_TOTAL = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int CNT_W  = 10;
  // 799>>4 = 49 and 524>>4 = 32 both need six bits
  localparam int CELL_W = 6;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axis_phase_t;

endpackage

// File: rtl/vga_stitch_timing_if.sv
// Raster timing bundle from the timing generator (master) to the pixel renderer (slave).
interface vga_stitch_timing_if #(parameter int CELL_LOG2 = 4);
  import vga_stitch_pkg::*;

  logic [CNT_W-1:0]     hpos;
  logic [CNT_W-1:0]     vpos;
  logic                 hsync;
  logic                 vsync;
  logic                 display_on;
  logic [7:0]           frame;
  logic                 frame_start;
  logic [CELL_W-1:0]    cell_x;
  logic [CELL_W-1:0]    cell_y;
  logic [CELL_LOG2-1:0] sub_x;
  logic [CELL_LOG2-1:0] sub_y;

  modport master (
    output hpos, vpos, hsync, vsync, display_on, frame, frame_start,
    output cell_x, cell_y, sub_x, sub_y
  );

  modport slave (
    input hpos, vpos, hsync, vsync, display_on, frame, frame_start,
    input cell_x, cell_y, sub_x, sub_y
  );

endinterface

// File: rtl/vga_stitch_timing_axis_counter.sv
// One raster axis: wrapping position counter with its blanking phase decoded from the count.
module vga_axis_counter
  import vga_stitch_pkg::*;
#(
  parameter int DISPLAY_LEN = 640,
  parameter int FRONT_LEN   = 16,
  parameter int SYNC_LEN    = 96,
  parameter int BACK_LEN    = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_step,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_nxt,
  output axis_phase_t      o_phase,
  output logic             o_wrap
);

  localparam int TOTAL = DISPLAY_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_nxt;
  logic             w_wrap;
  axis_phase_t      w_phase;

  // Phase describes the value the counter takes on the coming edge, so the
  // caller can register sync outputs aligned with the count.
  always_comb begin
    w_wrap = i_step && (r_count == CNT_W'(TOTAL - 1));
    if (w_wrap)      w_nxt = '0;
    else if (i_step) w_nxt = r_count + 1'b1;
    else             w_nxt = r_count;

    if (w_nxt < CNT_W'(DISPLAY_LEN))                              w_phase = ACTIVE;
    else if (w_nxt < CNT_W'(DISPLAY_LEN + FRONT_LEN))             w_phase = FRONT;
    else if (w_nxt < CNT_W'(DISPLAY_LEN + FRONT_LEN + SYNC_LEN))  w_phase = SYNC;
    else                                                          w_phase = BACK;
  end

  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else     r_count <= w_nxt;
  end

  assign o_count     = r_count;
  assign o_count_nxt = w_nxt;
  assign o_phase     = w_phase;
  assign o_wrap      = w_wrap;

endmodule

// File: rtl/vga_stitch_timing.sv
// VGA raster timing with stitch-grid coordinates; define STITCH_GRID_EN to build
// the cell_x/cell_y/sub_x/sub_y registers, otherwise those outputs are tied to 0.
module vga_stitch_timing
  import vga_stitch_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int CELL_LOG2 = CELL_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  vga_stitch_timing_if.master vid
);

  logic [CNT_W-1:0] w_h_count, w_h_nxt, w_v_count, w_v_nxt;
  axis_phase_t      w_h_phase, w_v_phase;
  logic             w_h_wrap, w_v_wrap;

  logic       r_hsync, r_vsync, r_display_on, r_frame_start;
  logic [7:0] r_frame;

  vga_axis_counter #(
    .DISPLAY_LEN(H_DISPLAY), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK)
  ) u_h_axis (
    .clk(clk), .rst(rst), .i_step(ena),
    .o_count(w_h_count), .o_count_nxt(w_h_nxt), .o_phase(w_h_phase), .o_wrap(w_h_wrap)
  );

  vga_axis_counter #(
    .DISPLAY_LEN(V_DISPLAY), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK)
  ) u_v_axis (
    .clk(clk), .rst(rst), .i_step(w_h_wrap),
    .o_count(w_v_count), .o_count_nxt(w_v_nxt), .o_phase(w_v_phase), .o_wrap(w_v_wrap)
  );

  // w_v_wrap can only rise with ena high, so frame_start drops to 0 while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_display_on  <= 1'b1;
      r_frame       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= (w_h_phase != SYNC);
      r_vsync       <= (w_v_phase != SYNC);
      r_display_on  <= (w_h_nxt < CNT_W'(H_DISPLAY)) && (w_v_nxt < CNT_W'(V_DISPLAY));
      r_frame_start <= w_v_wrap;
      if (w_v_wrap) r_frame <= r_frame + 8'd1;
    end
  end

  assign vid.hpos        = w_h_count;
  assign vid.vpos        = w_v_count;
  assign vid.hsync       = r_hsync;
  assign vid.vsync       = r_vsync;
  assign vid.display_on  = r_display_on;
  assign vid.frame       = r_frame;
  assign vid.frame_start = r_frame_start;

`ifdef STITCH_GRID_EN
  logic [CELL_W-1:0]    r_cell_x, r_cell_y;
  logic [CELL_LOG2-1:0] r_sub_x, r_sub_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cell_x <= '0;
      r_cell_y <= '0;
      r_sub_x  <= '0;
      r_sub_y  <= '0;
    end else begin
      r_cell_x <= CELL_W'(w_h_nxt >> CELL_LOG2);
      r_cell_y <= CELL_W'(w_v_nxt >> CELL_LOG2);
      r_sub_x  <= w_h_nxt[CELL_LOG2-1:0];
      r_sub_y  <= w_v_nxt[CELL_LOG2-1:0];
    end
  end

  assign vid.cell_x = r_cell_x;
  assign vid.cell_y = r_cell_y;
  assign vid.sub_x  = r_sub_x;
  assign vid.sub_y  = r_sub_y;
`else
  assign vid.cell_x = '0;
  assign vid.cell_y = '0;
  assign vid.sub_x  = {CELL_LOG2{1'b0}};
  assign vid.sub_y  = {CELL_LOG2{1'b0}};
`endif

endmodule
